cube_frame_loader: RTL and testbench

Double-buffered frame store on the write side of the 8x8x8 LED cube display path. Accepts a byte stream (one byte per latch row, 64 bytes per frame) over a valid/ready handshake, fills a hidden back bank, and swaps it into the display bank only at a frame boundary signalled by the cube driver. The cube driver reads the display bank through a zero-latency read port addressed by `{layer_i, latch_i}`, so a frame is never shown half-written.

---
 rtl/cube_frame_loader.sv | 80 ++++++++
 tb/tb_cube_frame_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cube_frame_loader.sv
// Double-buffered 64-byte LED cube frame store; bytes land in the hidden bank, swapped in on frame_sync.
// Zero-latency display read; in_ready drops while a completed frame waits for its swap.
module cube_frame_loader #(
  parameter int FRAME_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_sof,
  output logic       in_ready,
  input  logic       frame_sync,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       frame_pending,
  output logic       disp_bank,
  output logic       sync_err,
  output logic [7:0] frame_count
);

  typedef enum logic {FILL, PENDING} state_t;

  state_t     state;
  logic [7:0] mem [2][FRAME_BYTES];
  logic [5:0] wr_ptr;
  logic       accept;
  logic [5:0] wr_addr;
  logic       wr_bank;

  assign in_ready      = (state == FILL);
  assign frame_pending = (state == PENDING);
  assign accept        = in_valid && in_ready;
  // A start-of-frame byte always resynchronises to address 0.
  assign wr_addr       = in_sof ? 6'd0 : wr_ptr;
  assign wr_bank       = ~disp_bank;
  assign rd_data       = mem[disp_bank][rd_addr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < FRAME_BYTES; i++) begin
          mem[b][i] <= 8'h00;
        end
      end
      state       <= FILL;
      wr_ptr      <= 6'd0;
      disp_bank   <= 1'b0;
      sync_err    <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      sync_err <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            mem[wr_bank][wr_addr] <= in_data;
            if (in_sof) begin
              sync_err <= (wr_ptr != 6'd0);
              wr_ptr   <= 6'd1;
            end else begin
              wr_ptr <= wr_ptr + 6'd1;
              if (wr_ptr == 6'(FRAME_BYTES - 1)) begin
                state <= PENDING;
              end
            end
          end
        end
        PENDING: begin
          // Only here is frame_sync a safe point to expose the new frame.
          if (frame_sync) begin
            disp_bank   <= ~disp_bank;
            frame_count <= frame_count + 8'd1;
            state       <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_cube_frame_loader.sv
// Directed bench for cube_frame_loader: swap timing, sof resync, randomised valid and reset recovery.
module tb_cube_frame_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sof;
  logic       in_ready;
  logic       frame_sync;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_pending;
  logic       disp_bank;
  logic       sync_err;
  logic [7:0] frame_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [8];

  cube_frame_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_sof       (in_sof),
    .in_ready     (in_ready),
    .frame_sync   (frame_sync),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .frame_pending(frame_pending),
    .disp_bank    (disp_bank),
    .sync_err     (sync_err),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sof     = 1'b0;
    in_data    = 8'h00;
    frame_sync = 1'b0;
    rd_addr    = 6'd0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one byte at a negedge, returns 1 time unit after the accepting posedge.
  task automatic send_byte(input logic [7:0] d, input logic sof, input logic fs);
    int n = 0;
    @(negedge clk);
    in_valid   = 1'b1;
    in_data    = d;
    in_sof     = sof;
    frame_sync = fs;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL send_byte_timeout: in_ready stuck low for data 0x%0h", d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid   = 1'b0;
    in_sof     = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic pulse_sync();
    @(negedge clk);
    in_valid   = 1'b0;
    in_sof     = 1'b0;
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
  endtask

  task automatic sweep(input string name, input logic [7:0] exp);
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a);
      #0.1;
      chk(name, 32'(rd_data), 32'(exp));
    end
  endtask

  task automatic send_frame(input logic [7:0] v);
    for (int k = 0; k < 64; k++) send_byte(v, k == 0, 1'b0);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_disp_bank", 32'(disp_bank), 32'd0);
    chk("rst_pending", 32'(frame_pending), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    sweep("rst_rd_zero", 8'h00);

    // Frame of ramp values 0..63
    for (int k = 0; k < 64; k++) begin
      send_byte(8'(k), k == 0, 1'b0);
      if (k == 62) begin
        chk("ramp_ready_before_last", 32'(in_ready), 32'd1);
        chk("ramp_pending_before_last", 32'(frame_pending), 32'd0);
      end
    end
    chk("ramp_ready_low", 32'(in_ready), 32'd0);
    chk("ramp_pending", 32'(frame_pending), 32'd1);
    idle();
    rd_addr = 6'd5;
    #1;
    chk("ramp_hidden_rd5", 32'(rd_data), 32'h00);
    pulse_sync();
    rd_addr = 6'd5;
    #1;
    chk("ramp_swap_rd5", 32'(rd_data), 32'h05);
    chk("ramp_disp_bank", 32'(disp_bank), 32'd1);
    chk("ramp_frame_count", 32'(frame_count), 32'd1);
    chk("ramp_ready_back", 32'(in_ready), 32'd1);
    chk("ramp_pending_clr", 32'(frame_pending), 32'd0);

    vecs[0] = '{6'd0,  8'h00};
    vecs[1] = '{6'd7,  8'h07};
    vecs[2] = '{6'd8,  8'h08};
    vecs[3] = '{6'd9,  8'h09};
    vecs[4] = '{6'd42, 8'h2A};
    vecs[5] = '{6'd56, 8'h38};
    vecs[6] = '{6'd62, 8'h3E};
    vecs[7] = '{6'd63, 8'h3F};
    for (int i = 0; i < 8; i++) begin
      rd_addr = vecs[i].addr;
      #1;
      chk("ramp_table_rd", 32'(rd_data), 32'(vecs[i].exp));
    end

    // frame_sync during FILL and coincident with the last accept must not swap
    for (int k = 0; k < 10; k++) send_byte(8'(8'h10 + k), k == 0, 1'b0);
    pulse_sync();
    chk("fill_sync_disp", 32'(disp_bank), 32'd1);
    chk("fill_sync_count", 32'(frame_count), 32'd1);
    chk("fill_sync_ready", 32'(in_ready), 32'd1);
    for (int k = 10; k < 63; k++) send_byte(8'(8'h10 + k), 1'b0, 1'b0);
    send_byte(8'h4F, 1'b0, 1'b1);
    idle();
    chk("coinc_sync_disp", 32'(disp_bank), 32'd1);
    chk("coinc_sync_count", 32'(frame_count), 32'd1);
    chk("coinc_sync_pending", 32'(frame_pending), 32'd1);
    pulse_sync();
    chk("late_sync_disp", 32'(disp_bank), 32'd0);
    chk("late_sync_count", 32'(frame_count), 32'd2);
    rd_addr = 6'd0;
    #1;
    chk("late_sync_rd0", 32'(rd_data), 32'h10);
    rd_addr = 6'd63;
    #1;
    chk("late_sync_rd63", 32'(rd_data), 32'h4F);

    // Frame A, then frame B under random valid with continuous reads
    send_frame(8'hAA);
    idle();
    pulse_sync();
    chk("frameA_count", 32'(frame_count), 32'd3);
    sweep("frameA_rd", 8'hAA);
    begin
      int cnt = 0;
      int cyc = 0;
      while (cnt < 64 && cyc < 2000) begin
        @(negedge clk);
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'h55;
        in_sof   = (cnt == 0);
        rd_addr  = 6'(cyc);
        #1;
        chk("mix_rd_during_B", 32'(rd_data), 32'hAA);
        if (in_valid && in_ready) cnt++;
        cyc++;
      end
      if (cnt < 64) begin
        errors++;
        $display("FAIL frameB_timeout: accepted %0d bytes, required 64", cnt);
      end
      @(posedge clk);
      #1;
    end
    idle();
    chk("frameB_pending", 32'(frame_pending), 32'd1);
    sweep("frameB_hidden_rd", 8'hAA);
    pulse_sync();
    chk("frameB_count", 32'(frame_count), 32'd4);
    chk("frameB_disp", 32'(disp_bank), 32'd0);
    sweep("frameB_rd", 8'h55);

    // sof after 20 bytes resynchronises and flags sync_err for one cycle
    for (int k = 0; k < 20; k++) send_byte(8'hEE, k == 0, 1'b0);
    chk("sof_no_err_yet", 32'(sync_err), 32'd0);
    send_byte(8'h81, 1'b1, 1'b0);
    chk("sof_err_pulse", 32'(sync_err), 32'd1);
    for (int j = 1; j < 64; j++) begin
      send_byte(8'(j), 1'b0, 1'b0);
      if (j == 1) chk("sof_err_clear", 32'(sync_err), 32'd0);
      if (j == 62) chk("sof_not_yet_pending", 32'(frame_pending), 32'd0);
    end
    chk("sof_pending", 32'(frame_pending), 32'd1);
    idle();
    pulse_sync();
    chk("sof_count", 32'(frame_count), 32'd5);
    rd_addr = 6'd0;
    #1;
    chk("sof_rd0", 32'(rd_data), 32'h81);
    rd_addr = 6'd20;
    #1;
    chk("sof_rd20", 32'(rd_data), 32'h14);
    rd_addr = 6'd63;
    #1;
    chk("sof_rd63", 32'(rd_data), 32'h3F);

    // Reset while a 0x7E frame is pending
    send_frame(8'h7E);
    idle();
    chk("pre_rst_pending", 32'(frame_pending), 32'd1);
    do_reset();
    chk("post_rst_pending", 32'(frame_pending), 32'd0);
    chk("post_rst_count", 32'(frame_count), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_disp", 32'(disp_bank), 32'd0);
    sweep("post_rst_rd", 8'h00);
    pulse_sync();
    chk("post_rst_sync_noswap", 32'(disp_bank), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
